cpu_trace_emitter: RTL and testbench

Serializes one structured CPU write-back/store record into the ASCII trace character stream that cpu_checker parses, one character per handshake.
- Register write format: "^<time>@<pc>: $<grf> <= <data>#"
- Memory write format: "^<time>@<pc>: *<addr> <= <data>#"
- Sits between the CPU model or trace source and cpu_checker or a UART/TX path; feeds bench and self-check stimulus.

---
 rtl/cpu_trace_pkg.sv | 36 +++
 rtl/trace_bin2bcd.sv | 56 +++++
 rtl/cpu_trace_emitter.sv | 186 ++++++++++++++++++
 tb/tb_cpu_trace_emitter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared constants, enums and helpers for the CPU trace emitter.
// Optional build macro TRACE_UPPERHEX_EN selects 'A'-'F' for hex digits 10-15.
package cpu_trace_pkg;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_LT     = 8'h3C;
  localparam logic [7:0] CH_EQ     = 8'h3D;
  localparam logic [7:0] CH_HASH   = 8'h23;
  localparam logic [7:0] CH_ZERO   = 8'h30;
`ifdef TRACE_UPPERHEX_EN
  localparam logic [7:0] CH_HEX_A  = 8'h41;
`else
  localparam logic [7:0] CH_HEX_A  = 8'h61;
`endif

  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_e;

  typedef enum logic [3:0] {
    F_HEAD, F_TIME, F_AT, F_PC, F_SEP, F_TGT, F_ARROW, F_DATA, F_TAIL
  } field_e;

  function automatic logic [7:0] nibble2ascii(input logic [3:0] n);
    if (n < 4'd10) return CH_ZERO + {4'h0, n};
    return CH_HEX_A + {4'h0, n} - 8'd10;
  endfunction

  function automatic logic [7:0] dec2ascii(input logic [3:0] d);
    return CH_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/trace_bin2bcd.sv
// Sequential double-dabble: one input bit per cycle, TIME_W cycles, 4 BCD digits.
module trace_bin2bcd #(
  parameter int TIME_W = 14
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [TIME_W-1:0] bin_i,
  output logic              done_o,
  output logic [15:0]       bcd_o
);

  localparam int CW = $clog2(TIME_W + 1);

  logic [TIME_W-1:0] bin_q;
  logic [15:0]       bcd_q, adj;
  logic [CW-1:0]     cnt_q;
  logic              busy_q, done_q;

  // Add-3 correction on every digit that would overflow after the shift.
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < 4; k++)
      if (bcd_q[k*4 +: 4] >= 4'd5) adj[k*4 +: 4] = bcd_q[k*4 +: 4] + 4'd3;
  end

  // Load on start, then shift one bit per cycle; done pulses after the last shift.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        bin_q  <= bin_i;
        bcd_q  <= '0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        {bcd_q, bin_q} <= {adj, bin_q} << 1;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CW'(TIME_W - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/cpu_trace_emitter.sv
// Serializes one register/memory write record into an ASCII trace line,
// one character per valid/ready handshake. Build macro TRACE_UPPERHEX_EN
// switches hex digits to uppercase.
module cpu_trace_emitter
  import cpu_trace_pkg::*;
#(
  parameter int TIME_W   = 14,
  parameter int TIME_MAX = 9999
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rec_valid_i,
  output logic              rec_ready_o,
  input  logic              rec_kind_i,
  input  logic [TIME_W-1:0] rec_time_i,
  input  logic [31:0]       rec_pc_i,
  input  logic [4:0]        rec_grf_i,
  input  logic [31:0]       rec_addr_i,
  input  logic [31:0]       rec_data_i,
  output logic [7:0]        char_o,
  output logic              char_valid_o,
  input  logic              char_ready_i,
  output logic              rec_done_o
);

  state_e      state_q, state_d;
  field_e      field_q, field_d;
  logic [3:0]  idx_q, idx_d;
  logic        done_q, done_d;
  logic        kind_q;
  logic [31:0] pc_q, addr_q, data_q;
  logic [4:0]  grf_q, grf_tens, grf_ones;
  logic [TIME_W-1:0] tclamp;
  logic [15:0] bcd;
  logic        bcd_done, accept, xfer, last;
  logic [1:0]  tstart;
  logic [2:0]  tgt_i;
  logic [7:0]  chr;

  assign rec_ready_o  = (state_q == IDLE) && reset_i;
  assign accept       = rec_valid_i && rec_ready_o;
  assign char_valid_o = (state_q == EMIT) && reset_i;
  assign char_o       = char_valid_o ? chr : 8'h00;
  assign xfer         = char_valid_o && char_ready_i;
  assign rec_done_o   = done_q;
  assign tclamp = (rec_time_i > TIME_W'(TIME_MAX)) ? TIME_W'(TIME_MAX) : rec_time_i;
  assign tgt_i  = idx_q[2:0] - 3'd1;

  trace_bin2bcd #(.TIME_W(TIME_W)) u_bcd (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (accept),
    .bin_i   (tclamp),
    .done_o  (bcd_done),
    .bcd_o   (bcd)
  );

  // Leading-zero skip for time, and tens/ones split of the register number.
  always_comb begin
    if (bcd[15:12] != 4'd0)     tstart = 2'd0;
    else if (bcd[11:8] != 4'd0) tstart = 2'd1;
    else if (bcd[7:4] != 4'd0)  tstart = 2'd2;
    else                        tstart = 2'd3;
    if (grf_q >= 5'd30)         grf_tens = 5'd3;
    else if (grf_q >= 5'd20)    grf_tens = 5'd2;
    else if (grf_q >= 5'd10)    grf_tens = 5'd1;
    else                        grf_tens = 5'd0;
    grf_ones = grf_q - grf_tens * 5'd10;
  end

  // Character for the current field/index and whether it ends the field.
  always_comb begin
    chr  = 8'h00;
    last = 1'b0;
    case (field_q)
      F_HEAD:  begin chr = CH_CARET; last = 1'b1; end
      F_TIME:  begin
        chr  = dec2ascii(bcd[{2'd3 - idx_q[1:0], 2'b00} +: 4]);
        last = (idx_q == 4'd3);
      end
      F_AT:    begin chr = CH_AT; last = 1'b1; end
      F_PC:    begin
        chr  = nibble2ascii(pc_q[{3'd7 - idx_q[2:0], 2'b00} +: 4]);
        last = (idx_q == 4'd7);
      end
      F_SEP:   begin
        chr  = (idx_q == 4'd0) ? CH_COLON : CH_SPACE;
        last = (idx_q == 4'd1);
      end
      F_TGT:   begin
        if (idx_q == 4'd0) begin
          chr = kind_q ? CH_STAR : CH_DOLLAR;
        end else if (kind_q) begin
          chr  = nibble2ascii(addr_q[{3'd7 - tgt_i, 2'b00} +: 4]);
          last = (idx_q == 4'd8);
        end else begin
          chr  = (grf_tens != 5'd0 && idx_q == 4'd1) ? dec2ascii(grf_tens[3:0])
                                                      : dec2ascii(grf_ones[3:0]);
          last = (grf_tens == 5'd0) ? (idx_q == 4'd1) : (idx_q == 4'd2);
        end
      end
      F_ARROW: begin
        case (idx_q)
          4'd1:    chr = CH_LT;
          4'd2:    chr = CH_EQ;
          default: chr = CH_SPACE;
        endcase
        last = (idx_q == 4'd3);
      end
      F_DATA:  begin
        chr  = nibble2ascii(data_q[{3'd7 - idx_q[2:0], 2'b00} +: 4]);
        last = (idx_q == 4'd7);
      end
      F_TAIL:  begin chr = CH_HASH; last = 1'b1; end
      default: ;
    endcase
  end

  // Next state: wait for the conversion, then walk the fields on each transfer.
  always_comb begin
    state_d = state_q;
    field_d = field_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = CONV;
      CONV: if (bcd_done) begin
        state_d = EMIT;
        field_d = F_HEAD;
        idx_d   = 4'd0;
      end
      EMIT: if (xfer) begin
        if (!last) begin
          idx_d = idx_q + 4'd1;
        end else begin
          idx_d = 4'd0;
          case (field_q)
            F_HEAD:  begin field_d = F_TIME; idx_d = {2'b00, tstart}; end
            F_TIME:  field_d = F_AT;
            F_AT:    field_d = F_PC;
            F_PC:    field_d = F_SEP;
            F_SEP:   field_d = F_TGT;
            F_TGT:   field_d = F_ARROW;
            F_ARROW: field_d = F_DATA;
            F_DATA:  field_d = F_TAIL;
            default: begin state_d = IDLE; done_d = 1'b1; end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      field_q <= F_HEAD;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Record capture so the inputs are free once the record is accepted.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      kind_q <= 1'b0;
      pc_q   <= '0;
      grf_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      kind_q <= rec_kind_i;
      pc_q   <= rec_pc_i;
      grf_q  <= rec_grf_i;
      addr_q <= rec_addr_i;
      data_q <= rec_data_i;
    end
  end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Self-checking bench for cpu_trace_emitter: expected trace lines are built
// with $sformatf from the record fields and compared with the captured stream.
module tb_cpu_trace_emitter;

  localparam int TW = 14;

  typedef struct {
    bit          kind;
    int unsigned t;
    logic [31:0] pc;
    logic [4:0]  grf;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          rec_valid_i = 1'b0;
  logic          rec_ready_o;
  logic          rec_kind_i = 1'b0;
  logic [TW-1:0] rec_time_i = '0;
  logic [31:0]   rec_pc_i = '0;
  logic [4:0]    rec_grf_i = '0;
  logic [31:0]   rec_addr_i = '0;
  logic [31:0]   rec_data_i = '0;
  logic [7:0]    char_o;
  logic          char_valid_o;
  logic          char_ready_i = 1'b1;
  logic          rec_done_o;

  int vectors = 0;
  int errors  = 0;

  cpu_trace_emitter #(.TIME_W(TW), .TIME_MAX(9999)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .rec_valid_i(rec_valid_i), .rec_ready_o(rec_ready_o),
    .rec_kind_i(rec_kind_i), .rec_time_i(rec_time_i), .rec_pc_i(rec_pc_i),
    .rec_grf_i(rec_grf_i), .rec_addr_i(rec_addr_i), .rec_data_i(rec_data_i),
    .char_o(char_o), .char_valid_o(char_valid_o), .char_ready_i(char_ready_i),
    .rec_done_o(rec_done_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic rec_t mk(bit k, int unsigned t, logic [31:0] pc, logic [4:0] g,
                              logic [31:0] a, logic [31:0] d);
    rec_t r;
    r.kind = k; r.t = t; r.pc = pc; r.grf = g; r.addr = a; r.data = d;
    return r;
  endfunction

  function automatic rec_t rnd_rec();
    return mk(1'($urandom_range(0, 1)), $urandom_range(0, (1 << TW) - 1), $urandom,
              5'($urandom_range(0, 31)), $urandom, $urandom);
  endfunction

  function automatic string hx(logic [31:0] v);
    string s;
    s = $sformatf("%08h", v);
`ifdef TRACE_UPPERHEX_EN
    s = s.toupper();
`endif
    return s;
  endfunction

  // Reference trace line straight from the record fields.
  function automatic string model(rec_t r);
    int unsigned tc;
    tc = (r.t > 9999) ? 9999 : r.t;
    if (!r.kind) return $sformatf("^%0d@%s: $%0d <= %s#", tc, hx(r.pc), r.grf, hx(r.data));
    return $sformatf("^%0d@%s: *%s <= %s#", tc, hx(r.pc), hx(r.addr), hx(r.data));
  endfunction

  // Minimal line classifier: 01 = register write, 10 = memory write.
  function automatic logic [1:0] fmt(string s);
    for (int i = 0; i + 2 < s.len(); i++)
      if (s[i] == 8'h3A) begin
        if (s[i+2] == 8'h24) return 2'b01;
        if (s[i+2] == 8'h2A) return 2'b10;
        return 2'b00;
      end
    return 2'b00;
  endfunction

  task automatic drive(input rec_t r);
    rec_kind_i = r.kind; rec_time_i = TW'(r.t); rec_pc_i = r.pc;
    rec_grf_i = r.grf; rec_addr_i = r.addr; rec_data_i = r.data;
  endtask

  // Offer a record and return at the first falling edge after acceptance.
  task automatic offer(input rec_t r, output bit ok);
    ok = 1'b0;
    @(negedge clk_i);
    drive(r);
    rec_valid_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (rec_ready_o === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk_i);
    end
    @(negedge clk_i);
    rec_valid_i = 1'b0;
    drive(rnd_rec());
  endtask

  // Capture one line. mode 0: ready always high; mode 1: 1010... plus a 5-cycle stall on '@'.
  task automatic collect(input int mode, output string s, output int lat, output int span,
                         output bit stable_ok, output bit done_ok);
    int cyc, first, stall;
    bit hold, tog, sawat, r, fin;
    logic [7:0] pch;
    cyc = 1; first = -1; stall = 0; hold = 0; tog = 1; sawat = 0; fin = 0; pch = 8'h00;
    s = ""; span = -1; stable_ok = 1'b1; done_ok = 1'b0;
    for (int n = 0; n < 400 && !fin; n++) begin
      if (hold && (char_valid_o !== 1'b1 || char_o !== pch)) stable_ok = 1'b0;
      if (stall > 0) begin r = 0; stall--; end
      else if (mode == 1 && char_valid_o === 1'b1 && char_o == 8'h40 && !sawat) begin
        sawat = 1; r = 0; stall = 4;
      end
      else if (mode == 1) begin r = tog; tog = !tog; end
      else r = 1;
      char_ready_i = r;
      if (char_valid_o === 1'b1) begin
        if (first < 0) first = cyc;
        hold = !r; pch = char_o;
        if (r) begin
          s = {s, $sformatf("%c", char_o)};
          if (char_o == 8'h23) begin fin = 1; span = cyc - first + 1; end
        end
      end else hold = 0;
      @(negedge clk_i);
      cyc++;
    end
    if (fin) begin
      done_ok = (rec_done_o === 1'b1 && rec_ready_o === 1'b1 && char_valid_o === 1'b0);
      @(negedge clk_i);
      done_ok = done_ok && (rec_done_o === 1'b0);
    end
    lat = (first < 0) ? -1 : first - 1;
    char_ready_i = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk_i);
    reset_i = 1'b0; rec_valid_i = 1'b1; drive(mk(0, 5, 32'h1, 5'd1, 0, 32'h2));
    repeat (2) @(negedge clk_i);
    vectors++;
    if (rec_ready_o !== 1'b0 || char_valid_o !== 1'b0 || char_o !== 8'h00 || rec_done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b valid=%b char=%h done=%b, need 0 0 00 0",
               rec_ready_o, char_valid_o, char_o, rec_done_o);
    end
    reset_i = 1'b1; rec_valid_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (rec_ready_o !== 1'b1 || char_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b valid=%b, need 1 0", rec_ready_o, char_valid_o);
    end
  endtask

  task automatic test_reg_record;
    rec_t r; string s; int lat, span; bit ok, st, dn;
    r = mk(0, 10, 32'h0000_3000, 5'd2, 32'h0, 32'h89ab_cd3f);
    offer(r, ok);
    vectors++;
    if (!ok || rec_ready_o !== 1'b0) begin
      errors++; $display("FAIL reg_accept: accepted=%b ready_after=%b, need 1 0", ok, rec_ready_o);
    end
    collect(0, s, lat, span, st, dn);
    vectors++;
    if (s != model(r)) begin errors++; $display("FAIL reg_string: got '%s' need '%s'", s, model(r)); end
    vectors++;
    if (s.len() !== 29 || span !== 29) begin
      errors++; $display("FAIL reg_length: got len=%0d span=%0d need 29 29", s.len(), span);
    end
    vectors++;
    if (lat !== TW + 1) begin errors++; $display("FAIL reg_latency: got %0d need %0d", lat, TW + 1); end
    vectors++;
    if (!dn) begin errors++; $display("FAIL reg_done: got pulse_ok=%b need 1", dn); end
  endtask

  task automatic test_mem_record;
    rec_t r; string s; int lat, span; bit ok, st, dn;
    r = mk(1, 6, 32'h0000_3000, 5'd0, 32'h0000_0088, 32'h89ab_cdef);
    offer(r, ok);
    collect(0, s, lat, span, st, dn);
    vectors++;
    if (s != model(r) || s.len() !== 35) begin
      errors++; $display("FAIL mem_string: got '%s' need '%s'", s, model(r));
    end
    vectors++;
    if (!ok || lat !== TW + 1 || span !== s.len() || !dn) begin
      errors++;
      $display("FAIL mem_timing: got acc=%b lat=%0d span=%0d done=%b need 1 %0d %0d 1",
               ok, lat, span, dn, TW + 1, s.len());
    end
  endtask

  task automatic test_edges;
    rec_t rs[5]; string s; int lat, span; bit ok, st, dn;
    rs[0] = mk(0, 0, 32'hdead_beef, 5'd0, 0, 32'h0);
    rs[1] = mk(0, 16383, 32'h0000_3000, 5'd31, 0, 32'hffff_ffff);
    rs[2] = mk(1, 9999, 32'ha5a5_5a5a, 5'd0, 32'hffff_fffc, 32'h1);
    rs[3] = mk(1, 10000, 32'h0, 5'd0, 32'h0, 32'h0);
    rs[4] = mk(0, 100, 32'h0123_4567, 5'd9, 0, 32'h89ab_cdef);
    foreach (rs[i]) begin
      offer(rs[i], ok);
      collect(0, s, lat, span, st, dn);
      vectors++;
      if (s != model(rs[i]) || !dn) begin
        errors++; $display("FAIL edge_%0d: got '%s' done=%b need '%s' 1", i, s, dn, model(rs[i]));
      end
    end
  endtask

  task automatic test_random;
    rec_t r; string s; int lat, span, mode; bit ok, st, dn;
    for (int i = 0; i < 8; i++) begin
      r = rnd_rec(); mode = $urandom_range(0, 1);
      offer(r, ok);
      collect(mode, s, lat, span, st, dn);
      vectors++;
      if (s != model(r)) begin
        errors++; $display("FAIL rand_%0d_string: got '%s' need '%s'", i, s, model(r));
      end
      vectors++;
      if (lat !== TW + 1 || !st || !dn) begin
        errors++; $display("FAIL rand_%0d_ctl: got lat=%0d stable=%b done=%b need %0d 1 1",
                           i, lat, st, dn, TW + 1);
      end
    end
  endtask

  task automatic test_backpressure;
    rec_t r; string s; int lat, span; bit ok, st, dn;
    r = mk(0, 10, 32'h0000_3000, 5'd2, 32'h0, 32'h89ab_cd3f);
    offer(r, ok);
    collect(1, s, lat, span, st, dn);
    vectors++;
    if (s != model(r)) begin errors++; $display("FAIL bp_string: got '%s' need '%s'", s, model(r)); end
    vectors++;
    if (!st || !dn || span <= s.len()) begin
      errors++; $display("FAIL bp_stable: got stable=%b done=%b span=%0d need 1 1 >%0d",
                         st, dn, span, s.len());
    end
  endtask

  task automatic test_midreset;
    rec_t r; string s; int lat, span, cnt; bit ok, st, dn;
    r = mk(1, 1234, 32'hcafe_f00d, 5'd0, 32'h1000_0000, 32'h0bad_c0de);
    offer(r, ok);
    cnt = 0; char_ready_i = 1'b1;
    for (int n = 0; n < 100 && cnt < 7; n++) begin
      if (char_valid_o === 1'b1) cnt++;
      if (cnt < 7) @(negedge clk_i);
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (cnt !== 7 || char_valid_o !== 1'b0 || char_o !== 8'h00 || rec_ready_o !== 1'b0) begin
      errors++; $display("FAIL midreset_abort: got sent=%0d valid=%b char=%h ready=%b need 7 0 00 0",
                         cnt, char_valid_o, char_o, rec_ready_o);
    end
    reset_i = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (rec_ready_o !== 1'b1 || char_valid_o !== 1'b0) begin
      errors++; $display("FAIL midreset_idle: got ready=%b valid=%b need 1 0", rec_ready_o, char_valid_o);
    end
    r = mk(0, 42, 32'h0000_4000, 5'd17, 0, 32'h1234_abcd);
    offer(r, ok);
    collect(0, s, lat, span, st, dn);
    vectors++;
    if (s != model(r) || lat !== TW + 1) begin
      errors++; $display("FAIL midreset_next: got '%s' lat=%0d need '%s' %0d", s, lat, model(r), TW + 1);
    end
  endtask

  task automatic test_back_to_back;
    rec_t a, b; string s, s1, s2; int nh, hpos; bit ok, acc2, acc_done;
    a = mk(0, 10, 32'h0000_3000, 5'd2, 0, 32'h89ab_cd3f);
    b = mk(1, 6, 32'h0000_3000, 5'd0, 32'h0000_0088, 32'h89ab_cdef);
    s = ""; nh = 0; acc2 = 0; acc_done = 0; ok = 0; hpos = -1;
    @(negedge clk_i);
    drive(a); rec_valid_i = 1'b1; char_ready_i = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (rec_ready_o === 1'b1) ok = 1; else @(negedge clk_i);
    end
    @(negedge clk_i);
    drive(b);
    for (int n = 0; n < 300 && nh < 2; n++) begin
      if (!acc2 && rec_valid_i && rec_ready_o === 1'b1) begin acc2 = 1; acc_done = (rec_done_o === 1'b1); end
      if (char_valid_o === 1'b1) begin
        s = {s, $sformatf("%c", char_o)};
        if (char_o == 8'h23) begin nh++; if (hpos < 0) hpos = s.len() - 1; end
      end
      @(negedge clk_i);
      if (acc2) rec_valid_i = 1'b0;
    end
    rec_valid_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (!ok || nh !== 2 || !acc_done) begin
      errors++; $display("FAIL b2b_handshake: got acc1=%b lines=%0d acc2_in_done=%b need 1 2 1", ok, nh, acc_done);
    end
    vectors++;
    if (s != {model(a), model(b)}) begin
      errors++; $display("FAIL b2b_string: got '%s' need '%s%s'", s, model(a), model(b));
    end
    s1 = (hpos >= 0) ? s.substr(0, hpos) : "";
    s2 = (hpos >= 0) ? s.substr(hpos + 1, s.len() - 1) : "";
    vectors++;
    if (fmt(s1) !== 2'b01 || fmt(s2) !== 2'b10) begin
      errors++; $display("FAIL b2b_format: got %b %b need 01 10", fmt(s1), fmt(s2));
    end
  endtask

  initial begin
    test_reset();
    test_reg_record();
    test_mem_record();
    test_edges();
    test_random();
    test_backpressure();
    test_midreset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
